wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and register file of the 5-stage pipeline. It consumes the registered MEM/WB bundle (control pair, data-memory word, ALU result, destination register) and selects the writeback value. It commits that value into a 32-entry register file and serves the two ID-stage read ports, with same-cycle write-to-read bypass. It also exports the effective writeback value and enable to the EX-stage forwarding logic, plus a retired-write counter for debug.

## Interface
- DATA_W, 32, datapath width of registers and writeback data
- RETIRE_W, 32, width of the retired-write counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_ctrl  in  2  writeback control from MEM/WB: [1] RegWrite, [0] MemToReg
- wb_dm_out  in  DATA_W  data-memory read word from MEM/WB
- wb_alu_out  in  DATA_W  ALU result from MEM/WB
- wb_write_reg  in  5  destination register index from MEM/WB
- rd_addr1  in  5  ID-stage read address, port 1 (rs)
- rd_addr2  in  5  ID-stage read address, port 2 (rt)
- rd_data1  out  DATA_W  read data, port 1
- rd_data2  out  DATA_W  read data, port 2
- wb_data  out  DATA_W  selected writeback value (to forwarding mux)
- wb_we  out  1  effective write enable (to forwarding unit)
- retire_count  out  RETIRE_W  number of register writes committed since reset

## Operation
- Data select, combinational:
  - wb_data = wb_ctrl[0] ? wb_dm_out : wb_alu_out.
  - wb_data is valid regardless of RegWrite.
- Effective enable, combinational: wb_we = wb_ctrl[1] && (wb_write_reg != 0).
- Register 0 is hardwired to zero:
  - Writes to index 0 are dropped and do not count.
  - Reads of index 0 always return 0, including under bypass.
- Commit: at rising clk with wb_we=1, regs[wb_write_reg] <= wb_data.
- Read ports are combinational. For each port n:
  - addr 0 -> 0.
  - Otherwise, if wb_we=1 and rd_addrn == wb_write_reg -> wb_data (bypass).
  - Otherwise -> regs[rd_addrn].
- Both read ports may hit the same register and the bypass simultaneously; both return wb_data.
- retire_count:
  - Increments by 1 at each rising clk where wb_we=1.
  - Wraps modulo 2^RETIRE_W without saturation or flag.
- No handshake. The block accepts one writeback bundle per cycle unconditionally; stalls and bubbles arrive upstream as wb_ctrl=2'b00.
- MemToReg with RegWrite=0 commits nothing; wb_data still reflects the selection.

## Timing
- Reset (async, rst=1):
  - All regs[1..31] cleared to 0 immediately; retire_count = 0.
  - rd_data1/rd_data2 read 0 unless bypassed.
  - wb_data and wb_we stay combinational functions of their inputs.
- While rst=1, no commit occurs and retire_count holds 0, even with wb_we=1.
- On rst deassertion, the first commit happens at the first rising clk with rst=0 and wb_we=1.
- Write latency: a value presented in cycle N is visible in the same cycle N via bypass. From cycle N+1 it comes from storage.
- ID reading a register that WB writes in the same cycle therefore needs no stall.
- Back-to-back writes to the same register in cycles N and N+1:
  - Cycle N+1 reads return the N+1 value (bypass).
  - Cycle N+2 reads return the N+1 value (storage).
- Reset asserted mid-sequence: any pending commit in that cycle is discarded; state is zero as above.
- No combinational path from rd_addr to wb_we or wb_data.

## Test plan
- Reset: hold rst=1 with wb_ctrl=2'b10, wb_write_reg=5, wb_alu_out=32'hDEAD_BEEF.
  - Required: regs[5]=0 and retire_count=0 after rst release.
  - rd_addr1=5 reads 32'hDEAD_BEEF only while that input is still presented with rst=0 (bypass).
- ALU vs memory select:
  - wb_ctrl=2'b10, reg 3, alu=32'h0000_1234, dm=32'hFFFF_0000 -> regs[3]=32'h0000_1234.
  - Then wb_ctrl=2'b11, reg 4 -> regs[4]=32'hFFFF_0000.
  - retire_count=2.
- Register 0 and disabled writes:
  - wb_ctrl=2'b10, reg 0, alu=32'h5555_5555 -> rd_data1 (addr 0)=0 and retire_count unchanged.
  - wb_ctrl=2'b01, reg 7 -> regs[7] unchanged and wb_we=0.
- Bypass on both ports:
  - regs[9] preloaded to 32'h1; present wb_ctrl=2'b10, reg 9, alu=32'h2 with rd_addr1=rd_addr2=9.
  - Required: both ports read 32'h2 in the same cycle; regs[9]=32'h2 the next cycle with inputs idle.
- Back-to-back writes to reg 12: values 32'hA then 32'hB in consecutive cycles.
  - Required: rd_addr2=12 reads A in cycle 1, B in cycle 2, B in cycle 3 (idle).
- Counter wrap with RETIRE_W=4: perform 17 enabled writes to reg 1.
  - Required: retire_count=1.
  - Assert rst mid-stream: retire_count=0 immediately and all regs read 0.

Source files
------------

// File: rtl/wb_regfile_if.sv
// MEM/WB writeback bundle plus the ID-stage read ports of the register file.
// The master drives the bundle and read addresses; the slave (regfile) returns data.
interface wb_regfile_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RETIRE_W = 32
);
    localparam int unsigned AW = 5;

    logic [1:0]          wb_ctrl;
    logic [DATA_W-1:0]   wb_dm_out;
    logic [DATA_W-1:0]   wb_alu_out;
    logic [AW-1:0]       wb_write_reg;
    logic [AW-1:0]       rd_addr1;
    logic [AW-1:0]       rd_addr2;
    logic [DATA_W-1:0]   rd_data1;
    logic [DATA_W-1:0]   rd_data2;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_we;
    logic [RETIRE_W-1:0] retire_count;

    modport master (
        output wb_ctrl, wb_dm_out, wb_alu_out, wb_write_reg, rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, wb_data, wb_we, retire_count
    );

    modport slave (
        input  wb_ctrl, wb_dm_out, wb_alu_out, wb_write_reg, rd_addr1, rd_addr2,
        output rd_data1, rd_data2, wb_data, wb_we, retire_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and 32-entry register file with two combinational read ports,
// same-cycle write-to-read bypass, and a retired-write counter.
module wb_regfile #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RETIRE_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    localparam int unsigned AW    = 5;
    localparam int unsigned NREGS = 32;

    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];
    logic [RETIRE_W-1:0] retire_count_q;
    logic [RETIRE_W-1:0] retire_count_d;

    logic [DATA_W-1:0]   wb_data_c;
    logic                wb_we_c;
    logic [DATA_W-1:0]   rd_data1_c;
    logic [DATA_W-1:0]   rd_data2_c;

    // Writeback select and effective enable; independent of the read addresses.
    always_comb begin
        wb_data_c = bus.wb_alu_out;
        if (bus.wb_ctrl[0]) begin
            wb_data_c = bus.wb_dm_out;
        end
        wb_we_c = bus.wb_ctrl[1] && (bus.wb_write_reg != AW'(0));
    end

    // Next-state for storage and counter; entry 0 is pinned to zero.
    always_comb begin
        regs_d         = regs_q;
        retire_count_d = retire_count_q;
        if (wb_we_c) begin
            regs_d[bus.wb_write_reg] = wb_data_c;
            retire_count_d           = retire_count_q + RETIRE_W'(1);
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            retire_count_q <= '0;
        end else begin
            regs_q         <= regs_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Read port 1: zero register, then bypass, then storage.
    always_comb begin
        rd_data1_c = regs_q[bus.rd_addr1];
        if (bus.rd_addr1 == AW'(0)) begin
            rd_data1_c = '0;
        end else if (wb_we_c && (bus.rd_addr1 == bus.wb_write_reg)) begin
            rd_data1_c = wb_data_c;
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd_data2_c = regs_q[bus.rd_addr2];
        if (bus.rd_addr2 == AW'(0)) begin
            rd_data2_c = '0;
        end else if (wb_we_c && (bus.rd_addr2 == bus.wb_write_reg)) begin
            rd_data2_c = wb_data_c;
        end
    end

    assign bus.wb_data      = wb_data_c;
    assign bus.wb_we        = wb_we_c;
    assign bus.rd_data1     = rd_data1_c;
    assign bus.rd_data2     = rd_data2_c;
    assign bus.retire_count = retire_count_q;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile, built with a 4-bit retire counter so wrap is reachable.
module tb_wb_regfile;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RETIRE_W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_regfile_if #(.DATA_W(DATA_W), .RETIRE_W(RETIRE_W)) bus ();

    wb_regfile #(.DATA_W(DATA_W), .RETIRE_W(RETIRE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_ctrl      = 2'b00;
        bus.wb_dm_out    = '0;
        bus.wb_alu_out   = '0;
        bus.wb_write_reg = '0;
    endtask

    task automatic present(input logic [1:0] ctrl, input logic [4:0] reg_idx,
                           input logic [31:0] alu, input logic [31:0] dm);
        bus.wb_ctrl      = ctrl;
        bus.wb_write_reg = reg_idx;
        bus.wb_alu_out   = alu;
        bus.wb_dm_out    = dm;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        present(2'b10, 5'd5, 32'hDEAD_BEEF, 32'h0);
        bus.rd_addr1 = 5'd5;
        bus.rd_addr2 = 5'd0;
        step();
        step();
        checks++;
        if (bus.retire_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count_held: got %0d want 0", bus.retire_count);
        end
        rst = 1'b0;
        #2;
        checks++;
        if (bus.rd_data1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reset_release_bypass: got %h want deadbeef", bus.rd_data1);
        end
        idle();
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_reg5_zero: got %h want 0", bus.rd_data1);
        end
        step();
        checks++;
        if (bus.rd_data1 !== 32'h0 || bus.retire_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_after_edge: rd1=%h cnt=%0d want 0/0", bus.rd_data1, bus.retire_count);
        end
    endtask

    task automatic test_select();
        present(2'b10, 5'd3, 32'h0000_1234, 32'hFFFF_0000);
        #1;
        checks++;
        if (bus.wb_data !== 32'h0000_1234 || bus.wb_we !== 1'b1) begin
            errors++;
            $display("FAIL select_alu: data=%h we=%b want 00001234/1", bus.wb_data, bus.wb_we);
        end
        step();
        present(2'b11, 5'd4, 32'h0000_1234, 32'hFFFF_0000);
        #1;
        checks++;
        if (bus.wb_data !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL select_mem: data=%h want ffff0000", bus.wb_data);
        end
        step();
        idle();
        bus.rd_addr1 = 5'd3;
        bus.rd_addr2 = 5'd4;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0000_1234 || bus.rd_data2 !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL select_stored: r3=%h r4=%h want 00001234/ffff0000", bus.rd_data1, bus.rd_data2);
        end
        checks++;
        if (bus.retire_count !== 4'd2) begin
            errors++;
            $display("FAIL select_count: got %0d want 2", bus.retire_count);
        end
    endtask

    task automatic test_reg0_disabled();
        present(2'b10, 5'd0, 32'h5555_5555, 32'h0);
        bus.rd_addr1 = 5'd0;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0 || bus.wb_we !== 1'b0 || bus.wb_data !== 32'h5555_5555) begin
            errors++;
            $display("FAIL reg0_write: rd1=%h we=%b data=%h want 0/0/55555555",
                     bus.rd_data1, bus.wb_we, bus.wb_data);
        end
        step();
        checks++;
        if (bus.retire_count !== 4'd2 || bus.rd_data1 !== 32'h0) begin
            errors++;
            $display("FAIL reg0_after: cnt=%0d rd1=%h want 2/0", bus.retire_count, bus.rd_data1);
        end
        present(2'b01, 5'd7, 32'h1111_1111, 32'h7777_7777);
        bus.rd_addr2 = 5'd7;
        #1;
        checks++;
        if (bus.wb_we !== 1'b0 || bus.wb_data !== 32'h7777_7777 || bus.rd_data2 !== 32'h0) begin
            errors++;
            $display("FAIL disabled_write: we=%b data=%h rd2=%h want 0/77777777/0",
                     bus.wb_we, bus.wb_data, bus.rd_data2);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.rd_data2 !== 32'h0 || bus.retire_count !== 4'd2) begin
            errors++;
            $display("FAIL disabled_after: r7=%h cnt=%0d want 0/2", bus.rd_data2, bus.retire_count);
        end
    endtask

    task automatic test_bypass_both();
        present(2'b10, 5'd9, 32'h1, 32'h0);
        step();
        present(2'b10, 5'd9, 32'h2, 32'h0);
        bus.rd_addr1 = 5'd9;
        bus.rd_addr2 = 5'd9;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h2 || bus.rd_data2 !== 32'h2) begin
            errors++;
            $display("FAIL bypass_both: rd1=%h rd2=%h want 2/2", bus.rd_data1, bus.rd_data2);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h2 || bus.rd_data2 !== 32'h2 || bus.retire_count !== 4'd4) begin
            errors++;
            $display("FAIL bypass_stored: rd1=%h rd2=%h cnt=%0d want 2/2/4",
                     bus.rd_data1, bus.rd_data2, bus.retire_count);
        end
    endtask

    task automatic test_back_to_back();
        bus.rd_addr2 = 5'd12;
        present(2'b10, 5'd12, 32'hA, 32'h0);
        #1;
        checks++;
        if (bus.rd_data2 !== 32'hA) begin
            errors++;
            $display("FAIL b2b_cycle1: got %h want a", bus.rd_data2);
        end
        step();
        present(2'b10, 5'd12, 32'hB, 32'h0);
        #1;
        checks++;
        if (bus.rd_data2 !== 32'hB) begin
            errors++;
            $display("FAIL b2b_cycle2: got %h want b", bus.rd_data2);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.rd_data2 !== 32'hB || bus.retire_count !== 4'd6) begin
            errors++;
            $display("FAIL b2b_cycle3: rd2=%h cnt=%0d want b/6", bus.rd_data2, bus.retire_count);
        end
    endtask

    task automatic test_wrap_and_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int i = 1; i <= 17; i++) begin
            present(2'b10, 5'd1, 32'(i), 32'h0);
            step();
        end
        idle();
        bus.rd_addr1 = 5'd1;
        #1;
        checks++;
        if (bus.retire_count !== 4'd1 || bus.rd_data1 !== 32'd17) begin
            errors++;
            $display("FAIL wrap_count: cnt=%0d r1=%0d want 1/17", bus.retire_count, bus.rd_data1);
        end
        present(2'b10, 5'd1, 32'd99, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.retire_count !== 4'd0) begin
            errors++;
            $display("FAIL midreset_count: got %0d want 0", bus.retire_count);
        end
        step();
        idle();
        #1;
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr1 = 5'(i);
            bus.rd_addr2 = 5'(31 - i);
            #1;
            checks++;
            if (bus.rd_data1 !== 32'h0 || bus.rd_data2 !== 32'h0) begin
                errors++;
                $display("FAIL midreset_regs[%0d]: rd1=%h rd2=%h want 0/0", i, bus.rd_data1, bus.rd_data2);
            end
        end
        rst = 1'b0;
        step();
        bus.rd_addr1 = 5'd1;
        #1;
        checks++;
        if (bus.rd_data1 !== 32'h0 || bus.retire_count !== 4'd0) begin
            errors++;
            $display("FAIL midreset_discard: r1=%h cnt=%0d want 0/0", bus.rd_data1, bus.retire_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;
        test_reset();
        test_select();
        test_reg0_disabled();
        test_bypass_both();
        test_back_to_back();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
